// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: queue read port plus serial-line outputs of the drain.
//
// Parameter:
//   DATA_W        byte width (matches the queue word width)
//
// Signals:
//   fifo_empty    queue empty flag, driven by the queue
//   fifo_data     queue registered read data, valid the cycle after a pop
//   fifo_read_en  single-cycle pop strobe, driven by the drain
//   tx            serial line (idles high)
//   busy          high from the pop strobe through the end of the stop bit
//   tx_done       one-cycle pulse on the last cycle of the stop bit
//
// Handshake: a pop is the single cycle in which fifo_read_en is high. The
// drain raises it only after it has seen fifo_empty low. The queue then
// presents the popped word on fifo_data in the following cycle. There is no
// back-pressure on the queue side.
//
// Modports: master = the drain (fifo_uart_tx), slave = the queue/line side.
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_read_en;
  logic              tx;
  logic              busy;
  logic              tx_done;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read_en,
    output tx,
    output busy,
    output tx_done
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_read_en,
    input  tx,
    input  busy,
    input  tx_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte queue and serialises each byte as an
// asynchronous 8N1 frame, LSB first.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (minimum 2)
//   DATA_W        byte width
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   bus        fifo_uart_tx_if.master (fifo_empty, fifo_data, fifo_read_en,
//              tx, busy, tx_done)
//   state_dbg  current FSM state encoding
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// All outputs are registered. They are computed from the next-state values,
// so each output lines up with the state it belongs to.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_uart_tx_if.master       bus,
  output logic [2:0]           state_dbg
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              bit_end;
  logic              tx_n, read_en_n, busy_n, done_n;
`ifdef UART_TX_PARITY_EN
  logic              parity, parity_n;
`endif

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      idx              <= '0;
      shift            <= '0;
      bus.tx           <= 1'b1;
      bus.fifo_read_en <= 1'b0;
      bus.busy         <= 1'b0;
      bus.tx_done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity           <= 1'b0;
`endif
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      idx              <= idx_n;
      shift            <= shift_n;
      bus.tx           <= tx_n;
      bus.fifo_read_en <= read_en_n;
      bus.busy         <= busy_n;
      bus.tx_done      <= done_n;
`ifdef UART_TX_PARITY_EN
      parity           <= parity_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shift_n   = shift;
`ifdef UART_TX_PARITY_EN
    parity_n  = parity;
`endif
    bit_end   = (cnt == CNT_MAX);
    tx_n      = 1'b1;
    read_en_n = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!bus.fifo_empty) state_n = ST_POP;
      end
      ST_POP: begin
        state_n = ST_LATCH;
      end
      ST_LATCH: begin
        // The queue's registered read data shows the popped byte here.
        shift_n = bus.fifo_data;
`ifdef UART_TX_PARITY_EN
        parity_n = ^bus.fifo_data;
`endif
        state_n = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = ST_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          if (idx == IDX_MAX) begin
            idx_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = ST_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase

    // Registered outputs are derived from the upcoming state so they are
    // valid in the same cycle as that state.
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_n = parity_n;
`endif
      default:   tx_n = 1'b1;
    endcase
    read_en_n = (state_n == ST_POP);
    busy_n    = (state_n != ST_IDLE);
    done_n    = (state_n == ST_STOP) && (cnt_n == CNT_MAX);
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Consumer-side drain for the 16-entry byte queue buffer. Pops one byte at a time through the queue's read port (read enable, empty flag, registered data out) and serialises each byte onto an asynchronous serial line: 8N1 framing, LSB first. Sits between the queue buffer and the board TX pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); minimum 2
DATA_W, 8, byte width; matches queue word width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
fifo_empty  input  1  queue empty flag (queue's isEmpty)
fifo_data  input  DATA_W  queue registered read data; valid the cycle after a pop
fifo_read_en  output  1  single-cycle pop strobe to queue read_en
tx  output  1  serial line; idles high
busy  output  1  high from pop strobe through end of stop bit
tx_done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (async, any state): FSM=IDLE, tx=1, busy=0, fifo_read_en=0, tx_done=0, baud counter=0, bit index=0, shift register=0. All outputs are registered.
- FSM states: IDLE, POP, LATCH, START, DATA, STOP.
- IDLE: tx=1. If fifo_empty==0, go to POP. Otherwise stay.
- POP: fifo_read_en=1 for exactly this cycle; busy=1. Go to LATCH.
- LATCH: capture fifo_data into the shift register. The queue presents the popped byte here (1-cycle read latency). Go to START.
- START: tx=0 for CLKS_PER_BIT cycles. Go to DATA with bit index=0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment bit index. After bit DATA_W-1, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. tx_done=1 on the final cycle. Then go to IDLE; busy drops on entering IDLE.
- Latency: pop strobe at cycle N means tx falls at N+2. One frame is 10*CLKS_PER_BIT cycles from start-bit edge to end of stop bit.
- Back-to-back bytes: queue non-empty at stop-bit end gives IDLE (1 cycle), POP, LATCH. tx stays high for stop + 3 cycles before the next start bit.
- Baud counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and holds 0 in IDLE/POP/LATCH.
- The block never asserts fifo_read_en while fifo_empty==1. It never asserts fifo_read_en outside POP, and at most once per frame.
- Once in POP, the byte is transmitted regardless of later fifo_empty changes. A concurrent queue write is ignored by this block.
- Reset mid-frame: tx returns high immediately. The partial frame is abandoned and that byte is lost (already popped). There is no pop in the reset cycle.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the DATA_W bits) for CLKS_PER_BIT cycles. Frame becomes 11*CLKS_PER_BIT cycles.
- Undefined: 8N1 as above; no PARITY state is compiled.

Test Plan:
1. Reset, CLKS_PER_BIT=4, fifo_empty=1 held for 100 cycles -> tx=1, fifo_read_en never 1, busy=0.
2. Queue holds 0xA5; fifo_empty falls -> one pop pulse; tx falls 2 cycles later. tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. tx_done pulses once at cycle 40 of the frame.
3. Queue holds 0x01,0xFF,0x80 -> exactly 3 pops, bytes sent in order. Idle-high gap before each next start is 4+3 cycles. fifo_empty=1 after third pop and no fourth pop occurs.
4. rst asserted in DATA bit 3 while sending 0x3C -> tx=1 asynchronously, busy=0. After release, the next queued byte 0x55 is popped and sent cleanly.
5. With UART_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0. Frame is 44 cycles.
6. Write to queue during STOP of byte 0x12 with 0x34 -> 0x34 popped after the 3-cycle IDLE/POP/LATCH gap. No double pop, no pop while empty.
